// File: rtl/sky_imem_loader.sv
// Byte-stream program loader: assembles LE words into imem, validates XOR checksum, holds core until done.
// Latency: write strobe one cycle after the 4th byte of a word; in_ready is a pure function of state.
module sky_imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    state_t      state;
    logic [15:0] n_words;
    logic [15:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] word_sr;
    logic [7:0]  csum;
    logic [15:0] hdr_n;
    logic        accept;

    assign in_ready = (state == HDR_LO) || (state == HDR_HI) ||
                      (state == DATA)   || (state == CSUM);
    // start takes priority, so a byte offered in the start cycle is dropped
    assign accept   = in_valid && in_ready && !start;
    assign hdr_n    = {in_data, n_words[7:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HDR_LO;
            n_words    <= '0;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            word_sr    <= '0;
            csum       <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= ADDR_W'(BASE_ADDR);
            imem_wdata <= '0;
            core_hold  <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (start) begin
                state     <= HDR_LO;
                n_words   <= '0;
                word_cnt  <= '0;
                byte_cnt  <= '0;
                word_sr   <= '0;
                csum      <= '0;
                core_hold <= 1'b1;
                load_done <= 1'b0;
                load_err  <= 1'b0;
            end else if (accept) begin
                case (state)
                    HDR_LO: begin
                        n_words[7:0] <= in_data;
                        state        <= HDR_HI;
                    end
                    HDR_HI: begin
                        n_words[15:8] <= in_data;
                        if (hdr_n == 16'd0) begin
                            state <= CSUM;
                        end else if ({1'b0, hdr_n} > 17'(DEPTH)) begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        csum     <= csum ^ in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        word_sr  <= {in_data, word_sr[23:8]};
                        if (byte_cnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_waddr <= ADDR_W'(BASE_ADDR) + word_cnt[ADDR_W-1:0];
                            imem_wdata <= {in_data, word_sr};
                            word_cnt   <= word_cnt + 16'd1;
                            if (word_cnt == n_words - 16'd1) begin
                                state <= CSUM;
                            end
                        end
                    end
                    CSUM: begin
                        if (in_data == csum) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sky_imem_loader.sv
// Directed bench for sky_imem_loader: framed byte images, write capture, status checks.
module tb_sky_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [9:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        load_done;
    logic        load_err;

    int checks   = 0;
    int failures = 0;

    logic [9:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    logic [7:0] img1[11] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                             8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};

    sky_imem_loader #(.ADDR_W(10), .DEPTH(1024), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_waddr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) chk("send_timeout", 32'd1, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_img1(input logic [7:0] csum_byte, input int max_gap);
        for (int i = 0; i < 11; i++) begin
            send((i == 10) ? csum_byte : img1[i],
                 (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_wr();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic chk_img1_writes(input string tag);
        chk({tag, "_nwr"}, wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            chk({tag, "_a0"}, {22'd0, wr_addr[0]}, 32'd0);
            chk({tag, "_d0"}, wr_data[0], 32'h12345678);
            chk({tag, "_a1"}, {22'd0, wr_addr[1]}, 32'd1);
            chk({tag, "_d1"}, wr_data[1], 32'hDEADBEEF);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_in_ready",  in_ready,   1);
        chk("rst_we",        imem_we,    0);
        chk("rst_waddr",     imem_waddr, 0);
        chk("rst_wdata",     imem_wdata, 0);
        chk("rst_hold",      core_hold,  1);
        chk("rst_done",      load_done,  0);
        chk("rst_err",       load_err,   0);

        // Case 1: two-word image, good checksum
        clear_wr();
        send_img1(8'h2A, 0);
        chk_img1_writes("c1");
        chk("c1_done",  load_done, 1);
        chk("c1_err",   load_err,  0);
        chk("c1_hold",  core_hold, 0);
        chk("c1_ready", in_ready,  0);
        chk("c1_waddr_hold", imem_waddr, 1);

        // Case 2: empty image, good then bad checksum
        pulse_start();
        chk("start_hold",  core_hold, 1);
        chk("start_done",  load_done, 0);
        chk("start_ready", in_ready,  1);
        clear_wr();
        send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        @(negedge clk);
        chk("c2a_nwr",  wr_addr.size(), 0);
        chk("c2a_done", load_done, 1);
        pulse_start();
        send(8'h00, 0); send(8'h00, 0); send(8'h01, 0);
        @(negedge clk);
        chk("c2b_err",  load_err,  1);
        chk("c2b_done", load_done, 0);
        chk("c2b_hold", core_hold, 1);

        // Case 3: bad checksum after full payload
        pulse_start();
        clear_wr();
        send_img1(8'h2B, 0);
        chk_img1_writes("c3");
        chk("c3_err",  load_err,  1);
        chk("c3_done", load_done, 0);
        chk("c3_hold", core_hold, 1);

        // Case 4: N = 1025 exceeds depth
        pulse_start();
        clear_wr();
        send(8'h01, 0); send(8'h04, 0);
        chk("c4_err",   load_err, 1);
        chk("c4_ready", in_ready, 0);
        in_valid = 1'b1; in_data = 8'h55;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        chk("c4_ready_after", in_ready, 0);
        chk("c4_nwr", wr_addr.size(), 0);
        chk("c4_hold", core_hold, 1);

        // Case 5: random valid gaps
        pulse_start();
        clear_wr();
        send_img1(8'h2A, 3);
        chk_img1_writes("c5");
        chk("c5_done", load_done, 1);

        // Case 6a: start mid-payload, byte offered in the start cycle must be dropped
        pulse_start();
        clear_wr();
        for (int i = 0; i < 7; i++) send(img1[i], 0);
        in_valid = 1'b1; in_data = 8'h02;
        pulse_start();
        in_valid = 1'b0;
        chk("c6a_ready", in_ready, 1);
        chk("c6a_nwr_partial", wr_addr.size(), 1);
        clear_wr();
        send_img1(8'h2A, 0);
        chk_img1_writes("c6a");
        chk("c6a_done", load_done, 1);

        // Case 6b: reset mid-payload
        pulse_start();
        clear_wr();
        for (int i = 0; i < 7; i++) send(img1[i], 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("c6b_waddr_rst", imem_waddr, 0);
        chk("c6b_hold_rst",  core_hold,  1);
        clear_wr();
        send_img1(8'h2A, 0);
        chk_img1_writes("c6b");
        chk("c6b_done", load_done, 1);
        chk("c6b_hold", core_hold, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
